lfsr_unit: RTL and testbench
============================

# lfsr_unit

Maximal-length Fibonacci linear-feedback shift register used as the pseudo-random noise source in the GPS synthesizer. It provides two outputs. The first is a purely combinational next-state function (`datain` → `dataout`), which callers can iterate with their own register. The second is a built-in clocked LFSR register with enable, seed load and lock-up protection. Both paths use the same feedback polynomial, selected by `WIDTH`.

## Interface
Parameters:
- `WIDTH`, default 8: register width; legal range 3..32; any other value is an elaboration error.
- `SEED`, default 1: reset and lock-up-recovery value of the internal register; must be nonzero and fit in `WIDTH` bits.

Ports:
- `clk`, input, 1: clock. Reset is `reset`, synchronous, active-high; clock is `clk`.
- `reset`, input, 1: synchronous, active-high reset of the internal register only.
- `datain`, input, WIDTH: state operand for the combinational step function.
- `dataout`, output, WIDTH: next state of `datain`; combinational.
- `en`, input, 1: advances the internal register one step per cycle.
- `load`, input, 1: loads `seed_in` into the internal register.
- `seed_in`, input, WIDTH: value for `load`.
- `state`, output, WIDTH: internal register contents.
- `bit_out`, output, 1: serial noise bit; equals `state[WIDTH-1]`.

## Operation
Step function `next(x)`:
- `fb` = XOR of x at the tap positions. Taps are 1-based, so tap n is `x[n-1]`.
- `next(x) = {x[WIDTH-2:0], fb}`, a left shift with the feedback bit entering at the LSB.
- `dataout = next(datain)` at all times. It does not depend on `clk`, `reset`, `en` or `load`.
- `next(0) = 0`. The combinational path has no lock-up correction.

Tap table, maximal length (period 2^WIDTH−1):
- 3:3,2; 4:4,3; 5:5,3; 6:6,5; 7:7,6; 8:8,6,5,4
- 9:9,5; 10:10,7; 11:11,9; 12:12,6,4,1; 13:13,4,3,1; 14:14,5,3,1
- 15:15,14; 16:16,15,13,4; 17:17,14; 18:18,11; 19:19,6,2,1; 20:20,17
- 21:21,19; 22:22,21; 23:23,18; 24:24,23,22,17; 25:25,22; 26:26,6,2,1
- 27:27,5,2,1; 28:28,25; 29:29,27; 30:30,6,4,1; 31:31,28; 32:32,22,2,1

Internal register, evaluated at each rising `clk` edge, in priority order:
1. `reset` = 1: `state <= SEED`.
2. `load` = 1: `state <= seed_in`; if `seed_in` = 0, load `SEED` instead.
3. `en` = 1: `state <= next(state)`; if `state` = 0, load `SEED` instead. This is defensive recovery.
4. Otherwise `state` holds.

## Timing
- `dataout` is zero-latency combinational. Any external register feeding `datain` from `dataout` advances one step per cycle.
- `state` and `bit_out` are registered and change one cycle after the qualifying `reset`, `load` or `en`.
- Reset value: `state` = `SEED`; `bit_out` = `SEED[WIDTH-1]` (0 for the default). `dataout` has no reset value; it always follows `datain`.
- `reset`, `load` and `en` asserted together: `reset` wins. `load` and `en` together: `load` wins, with no step in that cycle.
- `reset` asserted mid-sequence: `state` = `SEED` on the next edge, and the sequence restarts from `SEED`.
- The register never holds 0 after any clock edge.

## Test plan
- WIDTH=8: external register seeded with 1 and fed back from `dataout` → sequence 0x01, 0x02, 0x04, 0x08, 0x11, 0x23, 0x47, 0x8E; returns to 0x01 after exactly 255 steps.
- WIDTH=8: all 256 `datain` values applied → `datain`=0 gives `dataout`=0; the 255 nonzero inputs give 255 distinct nonzero outputs.
- Internal register, WIDTH=8: reset, then `en`=1 for 255 cycles → `state` visits every nonzero value once and returns to 0x01. `bit_out` = `state[7]` throughout.
- `load`=1 with `seed_in`=0x00 → `state`=`SEED`. `load`=1 with `seed_in`=0xA5 → `state`=0xA5. `load` and `en` both high → loaded value, no step.
- `reset` asserted together with `load`, and separately mid-run with `en`=1 → `state`=0x01 on the next edge. `en`=0 → `state` holds.
- Period check for each WIDTH 3..16 → combinational and registered paths each have period exactly 2^WIDTH−1.

Source files
------------

// File: rtl/lfsr_unit.sv
// Maximal-length Fibonacci LFSR: a combinational step function plus a clocked
// noise register with enable, seed load and lock-up recovery.
module lfsr_unit #(
   parameter int              WIDTH = 8,
   parameter longint unsigned SEED  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] datain,
   output logic [WIDTH-1:0] dataout,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   output logic [WIDTH-1:0] state,
   output logic             bit_out
);

   generate
      if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
         $error("lfsr_unit: WIDTH must be in 3..32");
      end
      if (SEED == 0 || (SEED >> WIDTH) != 0) begin : g_bad_seed
         $error("lfsr_unit: SEED must be nonzero and fit in WIDTH bits");
      end
   endgenerate

   // Bit n-1 set for each 1-based tap n of the maximal-length polynomial.
   function automatic logic [31:0] tap_mask(input int w);
      case (w)
         3:       return 32'h0000_0006;
         4:       return 32'h0000_000C;
         5:       return 32'h0000_0014;
         6:       return 32'h0000_0030;
         7:       return 32'h0000_0060;
         8:       return 32'h0000_00B8;
         9:       return 32'h0000_0110;
         10:      return 32'h0000_0240;
         11:      return 32'h0000_0500;
         12:      return 32'h0000_0829;
         13:      return 32'h0000_100D;
         14:      return 32'h0000_2015;
         15:      return 32'h0000_6000;
         16:      return 32'h0000_D008;
         17:      return 32'h0001_2000;
         18:      return 32'h0002_0400;
         19:      return 32'h0004_0023;
         20:      return 32'h0009_0000;
         21:      return 32'h0014_0000;
         22:      return 32'h0030_0000;
         23:      return 32'h0042_0000;
         24:      return 32'h00E1_0000;
         25:      return 32'h0120_0000;
         26:      return 32'h0200_0023;
         27:      return 32'h0400_0013;
         28:      return 32'h0900_0000;
         29:      return 32'h1400_0000;
         30:      return 32'h2000_0029;
         31:      return 32'h4800_0000;
         32:      return 32'h8020_0003;
         default: return 32'h0000_0000;
      endcase
   endfunction

   localparam logic [31:0]      TAPS_ALL = tap_mask(WIDTH);
   localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SEED_W   = WIDTH'(SEED);

   logic [WIDTH-1:0] comb_taps;
   logic [WIDTH-1:0] reg_taps;
   logic [WIDTH-1:0] state_step;
   logic [WIDTH-1:0] state_d;
   logic [WIDTH-1:0] state_q;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_taps
      assign comb_taps[gi] = datain[gi]  & TAPS[gi];
      assign reg_taps[gi]  = state_q[gi] & TAPS[gi];
   end

   assign dataout    = {datain[WIDTH-2:0], ^comb_taps};
   assign state_step = {state_q[WIDTH-2:0], ^reg_taps};

   // Zero is the lock-up state; both load and step fall back to SEED instead.
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = (seed_in == '0) ? SEED_W : seed_in;
      end else if (en) begin
         state_d = (state_q == '0) ? SEED_W : state_step;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SEED_W;
      end else begin
         state_q <= state_d;
      end
   end

   assign state   = state_q;
   assign bit_out = state_q[WIDTH-1];

endmodule

// File: tb/tb_lfsr_unit.sv
// Self-checking bench for lfsr_unit: WIDTH=8 directed and random checks
// against a reference model, plus period checks for WIDTH 3..16.
module tb_lfsr_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset   = 1'b1;
   logic       en      = 1'b0;
   logic       load    = 1'b0;
   logic [7:0] datain  = 8'h00;
   logic [7:0] seed_in = 8'h00;
   logic [7:0] dataout;
   logic [7:0] state;
   logic       bit_out;

   lfsr_unit #(.WIDTH(8), .SEED(1)) dut (
      .clk     (clk),
      .reset   (reset),
      .datain  (datain),
      .dataout (dataout),
      .en      (en),
      .load    (load),
      .seed_in (seed_in),
      .state   (state),
      .bit_out (bit_out)
   );

   int passed = 0;
   int total  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Reference: polynomial x^8+x^6+x^5+x^4+1 evaluated from the tap list.
   function automatic logic [7:0] ref_next(input logic [7:0] x);
      int          taps [4] = '{8, 6, 5, 4};
      int unsigned fb = 0;
      int unsigned v  = x;
      foreach (taps[i]) fb = fb ^ ((v >> (taps[i] - 1)) & 1);
      return 8'((v * 2 + fb) % 256);
   endfunction

   function automatic logic [7:0] ref_reg(input logic [7:0] cur, input logic r,
                                          input logic l, input logic e, input logic [7:0] s);
      if (r) return 8'h01;
      if (l) return (s == 8'h00) ? 8'h01 : s;
      if (e) return (cur == 8'h00) ? 8'h01 : ref_next(cur);
      return cur;
   endfunction

   // Period checks: one free-running instance per width, stepped together.
   logic p_reset = 1'b1;
   logic p_en    = 1'b0;
   int   rper_w [3:16];
   int   cper_w [3:16];
   logic bad_w  [3:16];

   for (genvar gi = 3; gi <= 16; gi++) begin : g_per
      logic [gi-1:0] ext_q;
      logic [gi-1:0] dout;
      logic [gi-1:0] st;
      logic          bo;
      int            cnt, rp, cp;
      logic          bad;

      lfsr_unit #(.WIDTH(gi), .SEED(1)) u_dut (
         .clk     (clk),
         .reset   (p_reset),
         .datain  (ext_q),
         .dataout (dout),
         .en      (p_en),
         .load    (1'b0),
         .seed_in ('0),
         .state   (st),
         .bit_out (bo)
      );

      always @(posedge clk) begin
         if (p_reset) begin
            cnt   <= 0;
            rp    <= 0;
            cp    <= 0;
            bad   <= 1'b0;
            ext_q <= gi'(1);
         end else begin
            if (p_en) begin
               cnt   <= cnt + 1;
               ext_q <= dout;
            end
            if (rp == 0 && cnt != 0 && st == gi'(1))    rp <= cnt;
            if (cp == 0 && cnt != 0 && ext_q == gi'(1)) cp <= cnt;
            if (bo !== st[gi-1]) bad <= 1'b1;
         end
      end

      assign rper_w[gi] = rp;
      assign cper_w[gi] = cp;
      assign bad_w[gi]  = bad;
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] m;
      logic [7:0] x;
      logic [7:0] exp8 [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
      bit         seen [256];
      int         distinct;
      int         ret;

      // Reset state
      @(negedge clk);
      m = 8'h01;
      check("reset_state", state, 8'h01);
      check("reset_bit_out", bit_out, 1'b0);
      reset = 1'b0;

      // Combinational step over every datain value
      foreach (seen[i]) seen[i] = 1'b0;
      distinct = 0;
      for (int v = 0; v < 256; v++) begin
         datain = 8'(v);
         @(negedge clk);
         check("comb_next", dataout, ref_next(8'(v)));
         if (v != 0 && dataout != 8'h00 && !seen[dataout]) distinct++;
         seen[dataout] = 1'b1;
      end
      check("comb_distinct_nonzero", distinct, 255);

      // External register fed back from dataout
      x   = 8'h01;
      ret = 0;
      for (int k = 0; k < 300 && ret == 0; k++) begin
         datain = x;
         @(negedge clk);
         x = dataout;
         if (k < 7) check("chain_seq", x, exp8[k+1]);
         if (x == 8'h01) ret = k + 1;
      end
      check("chain_period", ret, 255);

      // Register held with en=0 throughout the combinational tests
      check("hold_idle", state, m);

      // Internal register free run
      foreach (seen[i]) seen[i] = 1'b0;
      distinct = 0;
      en = 1'b1;
      for (int k = 0; k < 255; k++) begin
         m = ref_reg(m, reset, load, en, seed_in);
         tick();
         check("run_state", state, m);
         check("run_bit_out", bit_out, m[7]);
         if (!seen[state]) distinct++;
         seen[state] = 1'b1;
      end
      check("run_return_seed", state, 8'h01);
      check("run_distinct", distinct, 255);

      // Load zero falls back to SEED
      repeat (3) tick();
      check("pre_load_state", state, 8'h08);
      en = 1'b0; load = 1'b1; seed_in = 8'h00;
      tick();
      check("load_zero", state, 8'h01);
      seed_in = 8'hA5;
      tick();
      check("load_a5", state, 8'hA5);
      seed_in = 8'h3C; en = 1'b1;
      tick();
      check("load_over_en", state, 8'h3C);
      load = 1'b0; en = 1'b0;
      repeat (2) tick();
      check("hold_en0", state, 8'h3C);

      // Reset priority over load and en
      en = 1'b1;
      repeat (4) tick();
      reset = 1'b1; load = 1'b1; seed_in = 8'h77;
      tick();
      check("reset_over_load", state, 8'h01);
      load = 1'b0; reset = 1'b0;
      repeat (5) tick();
      reset = 1'b1;
      tick();
      check("reset_mid_run", state, 8'h01);
      reset = 1'b0;
      tick();
      check("restart_from_seed", state, 8'h02);
      m = 8'h02;

      // Randomised control and data
      for (int k = 0; k < 400; k++) begin
         reset   = ($urandom_range(0, 99) < 4);
         load    = ($urandom_range(0, 5) == 0);
         en      = 1'($urandom_range(0, 1));
         seed_in = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         datain  = 8'($urandom);
         m = ref_reg(m, reset, load, en, seed_in);
         tick();
         check("rand_state", state, m);
         check("rand_bit_out", bit_out, m[7]);
         check("rand_comb", dataout, ref_next(datain));
      end
      reset = 1'b0; load = 1'b0; en = 1'b0;

      // Period of each width 3..16
      p_reset = 1'b0;
      p_en    = 1'b1;
      repeat (65540) @(negedge clk);
      p_en = 1'b0;
      for (int w = 3; w <= 16; w++) begin
         check($sformatf("reg_period_w%0d", w), rper_w[w], (1 << w) - 1);
         check($sformatf("comb_period_w%0d", w), cper_w[w], (1 << w) - 1);
         check($sformatf("bit_out_w%0d", w), bad_w[w], 1'b0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
